// File: rtl/dino_pkg.sv
// Shared constants for the dino game front end: tick index names and counter sizing.
package dino_pkg;

    localparam int TICK_FRAME = 0;
    localparam int TICK_PHYS  = 1;

    typedef logic [1:0] tick_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One push-button: polarity fix, 2-FF synchroniser, stability debouncer and a press
// latch that holds a debounced press until the next frame tick.
module button_debouncer
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic frame_tick,
    output logic btn_out
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);

    logic          pin_level;
    logic [1:0]    sync_q, sync_d;
    logic          s;
    logic          db_q, db_d;
    logic [DW-1:0] dc_q, dc_d;
    logic          pend_q, pend_d;

    assign pin_level = BTN_ACTIVE_LOW ? ~btn_raw : btn_raw;
    assign s         = sync_q[1];

    always_comb begin
        sync_d = {sync_q[0], pin_level};
        db_d   = db_q;
        dc_d   = dc_q;
        if (s == db_q) begin
            dc_d = '0;
        end else if (dc_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            db_d = s;
            dc_d = '0;
        end else begin
            dc_d = dc_q + 1'b1;
        end
    end

    // A new debounced press wins over the frame-tick clear on the same edge.
    always_comb begin
        pend_d = pend_q;
        if (db_d && !db_q) begin
            pend_d = 1'b1;
        end else if (frame_tick) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            dc_q   <= '0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            db_q   <= db_d;
            dc_q   <= dc_d;
            pend_q <= pend_d;
        end
    end

    assign btn_out = db_q | pend_q;

endmodule

// File: rtl/input_conditioner.sv
// Player-path front end: frame/physics tick generation and conditioned up/down buttons.
module input_conditioner
    import dino_pkg::*;
#(
    parameter int TICK_DIV        = 416667,
    parameter int PHASE_OFFSET    = 208333,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    output logic [1:0] game_tick,
    output logic       button_up,
    output logic       button_down
);

    localparam int FW = cnt_width(TICK_DIV);

    logic [FW-1:0] fc_q, fc_d;
    tick_t         tick_q, tick_d;

    // Ticks are decoded from the value fc is leaving, so they appear the cycle after it arrives.
    always_comb begin
        fc_d   = fc_q;
        tick_d = '0;
        if (tick_en) begin
            if (fc_q == FW'(TICK_DIV - 1)) begin
                fc_d = '0;
            end else begin
                fc_d = fc_q + 1'b1;
            end
            tick_d[TICK_FRAME] = (fc_q == FW'(TICK_DIV - 1));
            tick_d[TICK_PHYS]  = (fc_q == FW'(PHASE_OFFSET - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_q   <= '0;
            tick_q <= '0;
        end else begin
            fc_q   <= fc_d;
            tick_q <= tick_d;
        end
    end

    assign game_tick = tick_q;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_db_up (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_up_raw),
        .frame_tick (tick_q[TICK_FRAME]),
        .btn_out    (button_up)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_db_down (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_down_raw),
        .frame_tick (tick_q[TICK_FRAME]),
        .btn_out    (button_down)
    );

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: a cycle-level reference model predicts every output
// cycle; directed scenarios add fixed-value checks at known cycles.
module tb_input_conditioner;

    localparam int TD = 10;
    localparam int PO = 4;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_en = 1'b1;
    logic       btn_up_raw = 1'b1;
    logic       btn_down_raw = 1'b1;
    logic [1:0] game_tick;
    logic       button_up;
    logic       button_down;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [1:0] tick;
        logic       up;
        logic       down;
    } exp_t;

    exp_t sb_q[$];

    input_conditioner #(
        .TICK_DIV        (TD),
        .PHASE_OFFSET    (PO),
        .DEBOUNCE_CYCLES (DB),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_en      (tick_en),
        .btn_up_raw   (btn_up_raw),
        .btn_down_raw (btn_down_raw),
        .game_tick    (game_tick),
        .button_up    (button_up),
        .button_down  (button_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Reference model: n counts enabled edges since reset; a button level becomes debounced once
    // the pin (seen two edges late) has held a new value for DB consecutive edges.
    int   n = 0;
    logic prev_t0 = 1'b0;
    logic pd1[2], pd2[2], last_s[2], db[2], pend[2];
    int   run[2];

    always @(posedge clk) begin : model
        exp_t e;
        logic p[2];
        logic s, t0, t1, rise;
        p[0] = ~btn_up_raw;
        p[1] = ~btn_down_raw;
        if (reset) begin
            n = 0;
            prev_t0 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                pd1[i] = 1'b0; pd2[i] = 1'b0; last_s[i] = 1'b0;
                db[i] = 1'b0; pend[i] = 1'b0; run[i] = 0;
            end
            e = '0;
        end else begin
            t0 = 1'b0;
            t1 = 1'b0;
            if (tick_en) begin
                n++;
                t0 = (n % TD == 0);
                t1 = (n % TD == PO);
            end
            for (int i = 0; i < 2; i++) begin
                s = pd2[i];
                pd2[i] = pd1[i];
                pd1[i] = p[i];
                if (s == last_s[i]) run[i]++;
                else run[i] = 1;
                last_s[i] = s;
                rise = 1'b0;
                if (s != db[i] && run[i] >= DB) begin
                    rise = s;
                    db[i] = s;
                end
                if (rise) pend[i] = 1'b1;
                else if (prev_t0) pend[i] = 1'b0;
            end
            prev_t0 = t0;
            e.tick = {t1, t0};
            e.up   = db[0] | pend[0];
            e.down = db[1] | pend[1];
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at cyc=%0d: got no expectation, required one", cyc);
        end else begin
            e = sb_q.pop_front();
            if ({game_tick, button_up, button_down} !== e) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d: got tick=%b up=%b down=%b, required tick=%b up=%b down=%b",
                         cyc, game_tick, button_up, button_down, e.tick, e.up, e.down);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cyc=%0d: got %0d, required %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic at_cycle(input int c);
        int guard = 0;
        while (cyc < c) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                $display("FAIL at_cycle_timeout: got cyc=%0d, required %0d", cyc, c);
                $fatal(1);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // Tick cadence
        at_cycle(4);  chk("tick_phys_4", game_tick, 2);
        at_cycle(5);  chk("tick_none_5", game_tick, 0);
        at_cycle(10); chk("tick_frame_10", game_tick, 1);
        at_cycle(14); chk("tick_phys_14", game_tick, 2);
        at_cycle(20); chk("tick_frame_20", game_tick, 1);

        // Glitch: 3 low cycles rejected
        at_cycle(30); #1 btn_up_raw = 1'b0;
        at_cycle(33); #1 btn_up_raw = 1'b1;
        at_cycle(40); chk("glitch_up", button_up, 0);

        // Clean press and release
        at_cycle(100); #1 btn_up_raw = 1'b0;
        at_cycle(105); chk("press_up_105", button_up, 0);
        at_cycle(106); chk("press_up_106", button_up, 1);
        at_cycle(125); chk("press_hold_125", button_up, 1);
        at_cycle(130); #1 btn_up_raw = 1'b1;
        at_cycle(135); chk("release_135", button_up, 1);
        at_cycle(137); chk("release_137", button_up, 0);

        // Short tap held by the press latch until the frame tick
        at_cycle(147); #1 btn_up_raw = 1'b0;
        at_cycle(151); #1 btn_up_raw = 1'b1;
        at_cycle(158); chk("tap_pending_158", button_up, 1);
        at_cycle(160); chk("tap_frame_up_160", button_up, 1);
        chk("tap_frame_tick_160", game_tick, 1);
        at_cycle(161); chk("tap_drop_161", button_up, 0);

        // Debounced rise on the edge that ends a frame-tick cycle
        at_cycle(175); #1 btn_up_raw = 1'b0;
        at_cycle(179); #1 btn_up_raw = 1'b1;
        at_cycle(186); chk("simul_pending_186", button_up, 1);
        at_cycle(190); chk("simul_frame_up_190", button_up, 1);
        chk("simul_frame_tick_190", game_tick, 1);
        at_cycle(191); chk("simul_drop_191", button_up, 0);

        // tick_en hold for 25 cycles
        at_cycle(203); #1 tick_en = 1'b0;
        at_cycle(210); chk("hold_tick_210", game_tick, 0);
        at_cycle(215); chk("hold_tick_215", game_tick, 0);
        at_cycle(220); chk("hold_tick_220", game_tick, 0);
        at_cycle(228); #1 tick_en = 1'b1;
        at_cycle(229); chk("resume_phys_229", game_tick, 2);
        at_cycle(234); chk("resume_none_234", game_tick, 0);
        at_cycle(235); chk("resume_frame_235", game_tick, 1);

        // Reset mid-operation
        at_cycle(240); #1 btn_up_raw = 1'b0;
        at_cycle(246); #1 btn_down_raw = 1'b0;
        at_cycle(248); chk("pre_reset_up", button_up, 1);
        #1 reset = 1'b1;
        #1;
        chk("reset_tick", game_tick, 0);
        chk("reset_up", button_up, 0);
        chk("reset_down", button_down, 0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        at_cycle(1);
        chk("post_reset_tick", game_tick, 0);
        chk("post_reset_up", button_up, 0);
        at_cycle(6);
        chk("post_reset_up_6", button_up, 1);
        chk("post_reset_down_6", button_down, 1);
        #1 begin btn_up_raw = 1'b1; btn_down_raw = 1'b1; end
        at_cycle(20);

        // Randomised phase, checked by the scoreboard alone
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 5) == 0) btn_up_raw = ~btn_up_raw;
            if ($urandom_range(0, 5) == 0) btn_down_raw = ~btn_down_raw;
            if ($urandom_range(0, 39) == 0) tick_en = ~tick_en;
            reset = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
